sub_deparser_seq: RTL

- Parametrised, sequential successor of the single-action sub-deparser.
- Latches one PHV together with a full vector of parse actions, walks the actions in order and emits one container per handshake: data, byte offset and size select.
- Skips invalid or malformed actions.
- Sits between the PHV FIFO and the deparser header-rewrite stage.

---
 rtl/sub_deparser_seq.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/sub_deparser_seq.sv
// Sequential sub-deparser: latches a PHV and its parse-action vector, then emits one
// container per handshake. Optional malformed-action counter: SUB_DEPARSER_SEQ_ERR_CNT_EN.
module sub_deparser_seq #(
  parameter int unsigned C_CONT_NUM         = 8,
  parameter int unsigned C_NUM_ACTIONS      = 10,
  parameter int unsigned C_PARSE_ACTION_LEN = 16,
  parameter int unsigned C_PHV_WIDTH        = C_CONT_NUM * 96
) (
  input  logic                                        clk,
  input  logic                                        aresetn,
  input  logic [C_PHV_WIDTH-1:0]                      phv_in,
  input  logic [C_NUM_ACTIONS*C_PARSE_ACTION_LEN-1:0] parse_actions_in,
  input  logic                                        phv_valid_in,
  output logic                                        phv_ready_out,
  output logic [47:0]                                 cont_data_out,
  output logic [6:0]                                  cont_offset_out,
  output logic [1:0]                                  cont_select_out,
  output logic                                        cont_last_out,
  output logic                                        cont_valid_out,
  input  logic                                        cont_ready_in,
  output logic                                        done_out,
  output logic [15:0]                                 err_cnt_out
);

  localparam int unsigned ACT_W     = 16;
  localparam int unsigned ACTV_W    = C_NUM_ACTIONS * C_PARSE_ACTION_LEN;
  localparam int unsigned IDX_W     = (C_NUM_ACTIONS > 1) ? $clog2(C_NUM_ACTIONS) : 1;
  localparam int unsigned ACT_SLOTS = 1 << IDX_W;
  localparam int unsigned MAX_CONT  = 8;
  localparam int unsigned BASE_4B   = 16 * C_CONT_NUM;
  localparam int unsigned BASE_6B   = 48 * C_CONT_NUM;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_NUM_ACTIONS - 1);
  localparam logic [3:0]       CONT_LIM = 4'(C_CONT_NUM);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  state_t             r_state, w_nxt_state;
  logic [IDX_W-1:0]   r_idx, w_nxt_idx;
  logic [C_PHV_WIDTH-1:0] r_phv, w_nxt_phv;
  logic [ACTV_W-1:0]  r_actions, w_nxt_actions;
  logic [47:0]        r_data, w_nxt_data;
  logic [6:0]         r_offset, w_nxt_offset;
  logic [1:0]         r_select, w_nxt_select;
  logic               r_last, w_nxt_last;
  logic               r_valid, w_nxt_valid;
  logic               r_done, w_nxt_done;
  logic               r_ready, w_nxt_ready;

  logic [ACT_W-1:0]   w_act_arr [ACT_SLOTS];
  logic [15:0]        w_slot2 [MAX_CONT];
  logic [31:0]        w_slot4 [MAX_CONT];
  logic [47:0]        w_slot6 [MAX_CONT];
  logic [ACT_W-1:0]   w_act;
  logic [2:0]         w_act_cidx;
  logic [1:0]         w_act_type;
  logic [6:0]         w_act_off;
  logic               w_act_ok;
  logic               w_any_later;
  logic [47:0]        w_data;
  logic               w_unused_rsvd;

  // An action is usable when enabled, typed, and pointing at an existing container
  function automatic logic act_ok(input logic [5:0] a);
    return a[0] && (a[5:4] != 2'b00) && ({1'b0, a[3:1]} < CONT_LIM);
  endfunction

  for (genvar g = 0; g < ACT_SLOTS; g++) begin : g_act
    if (g < C_NUM_ACTIONS) begin : g_used
      assign w_act_arr[g] = r_actions[g*C_PARSE_ACTION_LEN +: ACT_W];
    end else begin : g_pad
      assign w_act_arr[g] = '0;
    end
  end

  // Slot tables are always 8 deep so the 3-bit index field never selects out of range
  for (genvar g = 0; g < MAX_CONT; g++) begin : g_slot
    if (g < C_CONT_NUM) begin : g_used
      assign w_slot2[g] = r_phv[16*g +: 16];
      assign w_slot4[g] = r_phv[BASE_4B + 32*g +: 32];
      assign w_slot6[g] = r_phv[BASE_6B + 48*g +: 48];
    end else begin : g_pad
      assign w_slot2[g] = '0;
      assign w_slot4[g] = '0;
      assign w_slot6[g] = '0;
    end
  end

  assign w_act         = w_act_arr[r_idx];
  assign w_act_cidx    = w_act[3:1];
  assign w_act_type    = w_act[5:4];
  assign w_act_off     = w_act[12:6];
  assign w_act_ok      = act_ok(w_act[5:0]);
  assign w_unused_rsvd = ^w_act[15:13];

  // Any usable action after the current one decides cont_last_out
  always_comb begin
    w_any_later = 1'b0;
    for (int k = 0; k < int'(C_NUM_ACTIONS); k++) begin
      if ((IDX_W'(k) > r_idx) && act_ok(w_act_arr[k][5:0])) w_any_later = 1'b1;
    end
  end

  always_comb begin
    w_data = '0;
    case (w_act_type)
      2'b01:   w_data = {32'd0, w_slot2[w_act_cidx]};
      2'b10:   w_data = {16'd0, w_slot4[w_act_cidx]};
      2'b11:   w_data = w_slot6[w_act_cidx];
      default: w_data = '0;
    endcase
  end

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_idx     = r_idx;
    w_nxt_phv     = r_phv;
    w_nxt_actions = r_actions;
    w_nxt_data    = r_data;
    w_nxt_offset  = r_offset;
    w_nxt_select  = r_select;
    w_nxt_last    = r_last;
    w_nxt_valid   = r_valid;
    w_nxt_done    = 1'b0;
    w_nxt_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_nxt_ready = 1'b1;
        if (phv_valid_in && r_ready) begin
          w_nxt_phv     = phv_in;
          w_nxt_actions = parse_actions_in;
          w_nxt_idx     = '0;
          w_nxt_ready   = 1'b0;
          w_nxt_state   = S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_act_ok) begin
          w_nxt_data   = w_data;
          w_nxt_offset = w_act_off;
          w_nxt_select = w_act_type;
          w_nxt_last   = !w_any_later;
          w_nxt_valid  = 1'b1;
          w_nxt_state  = S_EMIT;
        end else if (r_idx == LAST_IDX) begin
          w_nxt_done  = 1'b1;
          w_nxt_state = S_IDLE;
        end else begin
          w_nxt_idx = r_idx + IDX_W'(1);
        end
      end
      S_EMIT: begin
        if (cont_ready_in) begin
          w_nxt_valid = 1'b0;
          if (r_last || (r_idx == LAST_IDX)) begin
            w_nxt_done  = 1'b1;
            w_nxt_state = S_IDLE;
          end else begin
            w_nxt_idx   = r_idx + IDX_W'(1);
            w_nxt_state = S_SCAN;
          end
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_phv     <= '0;
      r_actions <= '0;
      r_data    <= '0;
      r_offset  <= '0;
      r_select  <= '0;
      r_last    <= 1'b0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      r_state   <= w_nxt_state;
      r_idx     <= w_nxt_idx;
      r_phv     <= w_nxt_phv;
      r_actions <= w_nxt_actions;
      r_data    <= w_nxt_data;
      r_offset  <= w_nxt_offset;
      r_select  <= w_nxt_select;
      r_last    <= w_nxt_last;
      r_valid   <= w_nxt_valid;
      r_done    <= w_nxt_done;
      r_ready   <= w_nxt_ready;
    end
  end

`ifdef SUB_DEPARSER_SEQ_ERR_CNT_EN
  logic [15:0] r_err_cnt;
  logic        w_malformed;

  // Enabled but not usable means malformed; counter saturates
  assign w_malformed = w_act[0] && !w_act_ok;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_err_cnt <= '0;
    end else if ((r_state == S_SCAN) && w_malformed && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_cnt_out = r_err_cnt;
`else
  assign err_cnt_out = '0;
`endif

  assign phv_ready_out   = r_ready;
  assign cont_data_out   = r_data;
  assign cont_offset_out = r_offset;
  assign cont_select_out = r_select;
  assign cont_last_out   = r_last;
  assign cont_valid_out  = r_valid;
  assign done_out        = r_done;

endmodule
